// File: rtl/bus1_arbiter_pkg.sv
// Shared bus1 sizes, C1 command codes, sequencer state type and command helpers
// used by the bus1 arbiter and its bench.
package bus1_arbiter_pkg;

  localparam int ADDR1_BUS_SIZE    = 15;
  localparam int CACHE_OFFSET_SIZE = 4;
  localparam int DATA1_BUS_SIZE    = 16;
  localparam int CTR1_BUS_SIZE     = 3;
  localparam int REQ_ADDR_SIZE     = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

  typedef logic [CTR1_BUS_SIZE-1:0] c1_t;

  localparam c1_t C1_NOP             = 3'd0;
  localparam c1_t C1_READ8           = 3'd1;
  localparam c1_t C1_READ16          = 3'd2;
  localparam c1_t C1_READ32          = 3'd3;
  localparam c1_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_t C1_WRITE8          = 3'd5;
  localparam c1_t C1_WRITE16         = 3'd6;
  localparam c1_t C1_WRITE32         = 3'd7;
  localparam c1_t C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND1, ST_SEND2, ST_WAIT, ST_RECV2, ST_DONE, ST_ERR
  } state_t;

  function automatic logic is_read(input c1_t cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  function automatic logic is_write(input c1_t cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  // Read data trimmed to the access width; everything that is not a read returns zero.
  function automatic logic [31:0] rsp_mask(input c1_t cmd, input logic [31:0] data);
    case (cmd)
      C1_READ8:  return {24'd0, data[7:0]};
      C1_READ16: return {16'd0, data[15:0]};
      C1_READ32: return data;
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/bus1_arbiter_if.sv
// Requester handshake plus split (drive/enable/resolved) bus1 signals.
interface bus1_arbiter_if;
  import bus1_arbiter_pkg::*;

  logic [1:0]                          req_valid;
  logic [1:0][CTR1_BUS_SIZE-1:0]       req_cmd;
  logic [1:0][REQ_ADDR_SIZE-1:0]       req_addr;
  logic [1:0][31:0]                    req_wdata;
  logic [1:0]                          req_ready;
  logic [1:0]                          rsp_valid;
  logic [31:0]                         rsp_data;
  logic                                rsp_err;
  logic [CTR1_BUS_SIZE-1:0]            c1_out;
  logic                                c1_oe;
  logic [ADDR1_BUS_SIZE-1:0]           a1_out;
  logic                                a1_oe;
  logic [DATA1_BUS_SIZE-1:0]           d1_out;
  logic                                d1_oe;
  logic [CTR1_BUS_SIZE-1:0]            c1_in;
  logic [DATA1_BUS_SIZE-1:0]           d1_in;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata, c1_in, d1_in,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           c1_out, c1_oe, a1_out, a1_oe, d1_out, d1_oe
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata, c1_in, d1_in,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           c1_out, c1_oe, a1_out, a1_oe, d1_out, d1_oe
  );
endinterface

// File: rtl/bus1_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the preferred requester flips away from whoever
// was granted on each accepted request.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/bus1_arbiter.sv
// Accepts whole commands from two requesters and sequences them onto bus1 as
// command+tag|set then offset, waits for the cache response and returns one reply.
module bus1_arbiter
  import bus1_arbiter_pkg::*;
#(
  parameter int RSP_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst_n,
  bus1_arbiter_if.slave  bus
);

  localparam int TIMER_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RSP_TIMEOUT - 1);

  state_t                    state_reg;
  c1_t                       cmd_reg;
  logic [REQ_ADDR_SIZE-1:0]  addr_reg;
  logic [31:0]               wdata_reg;
  logic [1:0]                gnt_reg;
  logic [DATA1_BUS_SIZE-1:0] data_lo_reg;
  logic [TIMER_W-1:0]        timer_reg;
  logic [1:0]                rsp_valid_reg;
  logic [31:0]               rsp_data_reg;
  logic                      rsp_err_reg;
  c1_t                       c1_out_reg;
  logic                      c1_oe_reg;
  logic [ADDR1_BUS_SIZE-1:0] a1_out_reg;
  logic                      a1_oe_reg;
  logic [DATA1_BUS_SIZE-1:0] d1_out_reg;
  logic                      d1_oe_reg;

  logic [1:0]                grant;
  logic                      accept;
  c1_t                       cmd_sel;
  logic [REQ_ADDR_SIZE-1:0]  addr_sel;
  logic [31:0]               wdata_sel;

  assign accept = (state_reg == ST_IDLE);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    cmd_sel   = grant[1] ? bus.req_cmd[1]   : bus.req_cmd[0];
    addr_sel  = grant[1] ? bus.req_addr[1]  : bus.req_addr[0];
    wdata_sel = grant[1] ? bus.req_wdata[1] : bus.req_wdata[0];
  end

  assign bus.req_ready = accept ? grant : 2'b00;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.c1_out    = c1_out_reg;
  assign bus.c1_oe     = c1_oe_reg;
  assign bus.a1_out    = a1_out_reg;
  assign bus.a1_oe     = a1_oe_reg;
  assign bus.d1_out    = d1_out_reg;
  assign bus.d1_oe     = d1_oe_reg;

  // Bus and response registers are loaded on the transition into the state that
  // presents them, so they are valid for the whole of that state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cmd_reg       <= C1_NOP;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      gnt_reg       <= '0;
      data_lo_reg   <= '0;
      timer_reg     <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      c1_out_reg    <= '0;
      c1_oe_reg     <= 1'b0;
      a1_out_reg    <= '0;
      a1_oe_reg     <= 1'b0;
      d1_out_reg    <= '0;
      d1_oe_reg     <= 1'b0;
    end else begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            cmd_reg   <= cmd_sel;
            addr_reg  <= addr_sel;
            wdata_reg <= wdata_sel;
            gnt_reg   <= grant;
            // RESPONSE shares its code with WRITE32, so only NOP is rejected here.
            if (cmd_sel == C1_NOP) begin
              state_reg     <= ST_ERR;
              rsp_valid_reg <= grant;
              rsp_err_reg   <= 1'b1;
            end else begin
              state_reg  <= ST_SEND1;
              c1_oe_reg  <= 1'b1;
              c1_out_reg <= cmd_sel;
              a1_oe_reg  <= 1'b1;
              a1_out_reg <= addr_sel[REQ_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
              d1_oe_reg  <= is_write(cmd_sel);
              d1_out_reg <= is_write(cmd_sel) ? wdata_sel[DATA1_BUS_SIZE-1:0] : '0;
            end
          end
        end
        ST_SEND1: begin
          state_reg  <= ST_SEND2;
          a1_out_reg <= {{(ADDR1_BUS_SIZE-CACHE_OFFSET_SIZE){1'b0}},
                         addr_reg[CACHE_OFFSET_SIZE-1:0]};
          if (cmd_reg == C1_WRITE32) begin
            d1_out_reg <= wdata_reg[31:16];
          end
        end
        ST_SEND2: begin
          state_reg  <= ST_WAIT;
          c1_oe_reg  <= 1'b0;
          c1_out_reg <= '0;
          a1_oe_reg  <= 1'b0;
          a1_out_reg <= '0;
          d1_oe_reg  <= 1'b0;
          d1_out_reg <= '0;
          timer_reg  <= '0;
        end
        ST_WAIT: begin
          // The first WAIT cycle is bus turnaround; C1_IN is ignored while timer is 0.
          if ((timer_reg != '0) && (bus.c1_in == C1_RESPONSE)) begin
            data_lo_reg <= bus.d1_in;
            if (cmd_reg == C1_READ32) begin
              state_reg <= ST_RECV2;
            end else begin
              state_reg     <= ST_DONE;
              rsp_valid_reg <= gnt_reg;
              rsp_data_reg  <= rsp_mask(cmd_reg, {16'd0, bus.d1_in});
            end
          end else if (timer_reg == TIMER_LAST) begin
            state_reg     <= ST_ERR;
            rsp_valid_reg <= gnt_reg;
            rsp_err_reg   <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        ST_RECV2: begin
          state_reg     <= ST_DONE;
          rsp_valid_reg <= gnt_reg;
          rsp_data_reg  <= rsp_mask(cmd_reg, {bus.d1_in, data_lo_reg});
        end
        ST_DONE:  state_reg <= ST_IDLE;
        ST_ERR:   state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus1_arbiter.sv
// Directed bench for bus1_arbiter: bus phases checked cycle by cycle, responses
// checked against a scoreboard of expected replies pushed when each request is issued.
module tb_bus1_arbiter;
  import bus1_arbiter_pkg::*;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  bus1_arbiter_if bus ();

  bus1_arbiter #(.RSP_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] vld, input logic [31:0] data, input logic err);
    exp_t e;
    e.vld  = vld;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Holds REQ_VALID until accepted (bounded), checks the grant, then drops it.
  task automatic issue(input int r, input c1_t cmd, input logic [18:0] addr, input logic [31:0] wd);
    int n;
    bus.req_valid[r] = 1'b1;
    bus.req_cmd[r]   = cmd;
    bus.req_addr[r]  = addr;
    bus.req_wdata[r] = wd;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready", {30'd0, bus.req_ready}, (r == 0) ? 32'd1 : 32'd2);
    acc_cyc = cyc;
    tick();
    bus.req_valid[r] = 1'b0;
  endtask

  // Waits (bounded) for a response, pops the scoreboard and checks latency.
  task automatic wait_rsp(input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    chk("rsp_seen", {31'd0, bus.rsp_valid != 2'b00}, 32'd1);
    if (bus.rsp_valid != 2'b00) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("rsp: valid=%b data=%h err=%b lat=%0d", bus.rsp_valid, bus.rsp_data, bus.rsp_err, cyc - acc_cyc);
        chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, e.vld});
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        chk("rsp_latency", cyc - acc_cyc, exp_lat);
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.c1_in     = '0;
    bus.d1_in     = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_oe", {29'd0, bus.c1_oe, bus.a1_oe, bus.d1_oe}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_a1_out", {17'd0, bus.a1_out}, 32'd0);
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // READ32 tag=0 set=2 offset=3
    push(2'b01, 32'hABCD1234, 1'b0);
    issue(0, C1_READ32, 19'h00023, 32'd0);
    chk("r32_send1_c1", {29'd0, bus.c1_out}, 32'd3);
    chk("r32_send1_a1", {17'd0, bus.a1_out}, 32'd2);
    chk("r32_send1_oe", {29'd0, bus.c1_oe, bus.a1_oe, bus.d1_oe}, 32'b110);
    tick();
    chk("r32_send2_a1", {17'd0, bus.a1_out}, 32'd3);
    chk("r32_send2_c1", {29'd0, bus.c1_out}, 32'd3);
    tick();
    chk("r32_wait_oe", {29'd0, bus.c1_oe, bus.a1_oe, bus.d1_oe}, 32'd0);
    tick();
    bus.c1_in = C1_RESPONSE;
    bus.d1_in = 16'h1234;
    tick();
    bus.d1_in = 16'hABCD;
    tick();
    bus.c1_in = '0;
    bus.d1_in = '0;
    wait_rsp(6);
    tick();

    // WRITE32 0xDEADBEEF
    push(2'b01, 32'd0, 1'b0);
    issue(0, C1_WRITE32, 19'h12345, 32'hDEADBEEF);
    chk("w32_send1_d1", {16'd0, bus.d1_out}, 32'hBEEF);
    chk("w32_send1_a1", {17'd0, bus.a1_out}, 32'h1234);
    chk("w32_send1_oe", {29'd0, bus.c1_oe, bus.a1_oe, bus.d1_oe}, 32'b111);
    tick();
    chk("w32_send2_d1", {16'd0, bus.d1_out}, 32'hDEAD);
    chk("w32_send2_a1", {17'd0, bus.a1_out}, 32'h5);
    tick();
    chk("w32_wait_oe", {29'd0, bus.c1_oe, bus.a1_oe, bus.d1_oe}, 32'd0);
    tick();
    bus.c1_in = C1_RESPONSE;
    tick();
    bus.c1_in = '0;
    wait_rsp(5);

    // Fresh reset, then both requesters hold INVALIDATE_LINE: grants alternate 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.req_cmd[0]   = C1_INVALIDATE_LINE;
    bus.req_cmd[1]   = C1_INVALIDATE_LINE;
    bus.req_addr[0]  = 19'h00010;
    bus.req_addr[1]  = 19'h00020;
    bus.req_valid    = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", {30'd0, bus.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      push((k % 2 == 0) ? 2'b01 : 2'b10, 32'd0, 1'b0);
      acc_cyc = cyc;
      tick();
      chk("rr_send1_c1", {29'd0, bus.c1_out}, 32'd4);
      chk("rr_busy_ready", {30'd0, bus.req_ready}, 32'd0);
      tick();
      tick();
      tick();
      bus.c1_in = C1_RESPONSE;
      tick();
      bus.c1_in = '0;
      wait_rsp(5);
      if (k == 3) bus.req_valid = 2'b00;
      tick();
    end

    // Cache silent: timeout after 8 WAIT cycles, then a normal READ16
    push(2'b10, 32'd0, 1'b1);
    issue(1, C1_READ16, 19'h00441, 32'd0);
    wait_rsp(11);
    push(2'b10, 32'h0000C3A5, 1'b0);
    issue(1, C1_READ16, 19'h00442, 32'd0);
    tick();
    tick();
    tick();
    bus.c1_in = C1_RESPONSE;
    bus.d1_in = 16'hC3A5;
    tick();
    bus.c1_in = '0;
    bus.d1_in = '0;
    wait_rsp(5);
    tick();

    // NOP is rejected without touching the bus
    push(2'b01, 32'd0, 1'b1);
    issue(0, C1_NOP, 19'h00001, 32'd0);
    chk("nop_c1_oe", {31'd0, bus.c1_oe}, 32'd0);
    wait_rsp(1);
    tick();
    chk("nop_c1_oe_after", {31'd0, bus.c1_oe}, 32'd0);

    // Reset during WAIT drops the request; pointer returns to requester 0
    issue(0, C1_READ8, 19'h00077, 32'd0);
    tick();
    tick();
    bus.c1_in = C1_RESPONSE;
    bus.d1_in = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", {29'd0, bus.c1_oe, bus.a1_oe, bus.d1_oe}, 32'd0);
    chk("arst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.c1_in = '0;
    bus.d1_in = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("arst_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    end
    bus.req_cmd[0]  = C1_READ8;
    bus.req_cmd[1]  = C1_READ8;
    bus.req_addr[0] = 19'h00100;
    bus.req_addr[1] = 19'h00200;
    bus.req_valid   = 2'b11;
    #1;
    chk("arst_ptr_grant", {30'd0, bus.req_ready}, 32'd1);
    push(2'b01, 32'h000000A7, 1'b0);
    acc_cyc = cyc;
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();
    bus.c1_in = C1_RESPONSE;
    bus.d1_in = 16'hBEA7;
    tick();
    bus.c1_in = '0;
    bus.d1_in = '0;
    wait_rsp(5);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
